// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble ALU result path: op encodings and FIFO entry layout.
// No logic; types and constants only.
// Not applicable.
package nibble_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int ENTRY_W = 7;

    // One captured ALU result; packed so the whole entry is a single 7-bit word.
    typedef struct packed {
        logic [1:0] op;
        logic       cout;
        logic [3:0] s;
    } entry_t;

endpackage

// File: rtl/nibble_edge_det.sv
// Rising-edge detector turning a level result-valid into a single capture pulse.
// Latency: cap is combinational in the cycle valid first rises.
// Backpressure: none; a held-high valid yields one pulse until it drops for a cycle.
module nibble_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic cap_o
);

    logic valid_q;

    // Remember last cycle's valid; resets high so a valid already asserted
    // when reset releases is not mistaken for a fresh result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b1;
        end else begin
            valid_q <= valid_i;
        end
    end

    assign cap_o = valid_i & ~valid_q;

endmodule

// File: rtl/nibble_result_fifo.sv
// Circular FIFO capturing ALU results on valid rising edges, drained by a read strobe.
// Latency: write visible in count next cycle; read data and q_valid one clock after rd.
// Backpressure: none upstream; captures while full (without a same-cycle read) are dropped and set ovf.
module nibble_result_fifo
    import nibble_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic [3:0]        s,
    input  logic              cout,
    input  logic              valid,
    input  logic              clr,
    input  logic              rd,
    output logic [1:0]        q_op,
    output logic [3:0]        q_s,
    output logic              q_cout,
    output logic              q_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovf
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic                cap;
    logic [ENTRY_W-1:0]  wr_entry;
    logic                do_rd;
    logic                do_wr;
    logic                drop;

    entry_t              mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    entry_t              q_q, q_d;
    logic                q_valid_q, q_valid_d;

    nibble_edge_det u_edge_det (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid),
        .cap_o   (cap)
    );

    assign wr_entry = {op, cout, s};

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // Qualify read/write; a read frees a slot in the same cycle, so a full
    // FIFO still accepts a capture when it is also being read. clr wins over both.
    always_comb begin
        do_rd = rd & ~empty & ~clr;
        do_wr = cap & ~clr & (~full | do_rd);
        drop  = cap & ~clr & full & ~do_rd;
    end

    // Next-state for pointers, occupancy, overflow flag and read data.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        q_d       = q_q;
        q_valid_d = 1'b0;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                q_d       = mem_q[rd_ptr_q];
                q_valid_d = 1'b1;
            end
            if (do_wr && !do_rd) begin
                count_d = count_q + CNT_ONE;
            end else if (do_rd && !do_wr) begin
                count_d = count_q - CNT_ONE;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    // Storage array; contents are don't-care after reset or flush, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= entry_t'(wr_entry);
        end
    end

    assign q_op    = q_q.op;
    assign q_s     = q_q.s;
    assign q_cout  = q_q.cout;
    assign q_valid = q_valid_q;
    assign count   = count_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_nibble_result_fifo.sv
// Bench for nibble_result_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
// Inputs driven on falling edges; outputs sampled 2 time units after rising edges.
module tb_nibble_result_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic [1:0] op;
    logic [3:0] s;
    logic       cout;
    logic       valid;
    logic       clr;
    logic       rd;
    logic [1:0] q_op;
    logic [3:0] q_s;
    logic       q_cout;
    logic       q_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    nibble_result_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .s       (s),
        .cout    (cout),
        .valid   (valid),
        .clr     (clr),
        .rd      (rd),
        .q_op    (q_op),
        .q_s     (q_s),
        .q_cout  (q_cout),
        .q_valid (q_valid),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] mq[$];
    logic       m_prev  = 1'b1;
    logic       m_ovf   = 1'b0;
    logic       m_qv    = 1'b0;
    logic [6:0] m_q     = '0;

    always @(posedge clk or posedge rst) begin
        logic rising;
        if (rst) begin
            mq.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
            m_qv   = 1'b0;
            m_q    = '0;
        end else begin
            rising = valid && !m_prev;
            m_prev = valid;
            if (clr) begin
                mq.delete();
                m_ovf = 1'b0;
                m_qv  = 1'b0;
            end else begin
                if (rd && mq.size() > 0) begin
                    m_q  = mq.pop_front();
                    m_qv = 1'b1;
                end else begin
                    m_qv = 1'b0;
                end
                if (rising) begin
                    if (mq.size() < DEPTH) mq.push_back({op, cout, s});
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #2;
        chk("m_q_valid", 32'(q_valid), 32'(m_qv));
        chk("m_q_op",    32'(q_op),    32'(m_q[6:5]));
        chk("m_q_cout",  32'(q_cout),  32'(m_q[4]));
        chk("m_q_s",     32'(q_s),     32'(m_q[3:0]));
        chk("m_count",   32'(count),   32'(mq.size()));
        chk("m_empty",   32'(empty),   32'(mq.size() == 0));
        chk("m_full",    32'(full),    32'(mq.size() == DEPTH));
        chk("m_ovf",     32'(ovf),     32'(m_ovf));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] o, input logic [3:0] sv, input logic c);
        op = o; s = sv; cout = c; valid = 1'b1;
        cyc(1);
        valid = 1'b0;
        cyc(1);
    endtask

    task automatic rd_pulse();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; op = 2'b00; s = 4'd0; cout = 1'b0; clr = 1'b0; rd = 1'b0;
        cyc(3);
        // Release reset with valid already high: must not capture.
        rst = 1'b0;
        cyc(5);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_q_s",   32'(q_s),   32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        valid = 1'b0;
        cyc(1);

        // Single entry round trip.
        push(2'b00, 4'd9, 1'b0);
        rd_pulse();
        chk("t2_qv",    32'(q_valid), 32'd1);
        chk("t2_op",    32'(q_op),    32'd0);
        chk("t2_s",     32'(q_s),     32'd9);
        chk("t2_cout",  32'(q_cout),  32'd0);
        chk("t2_count", 32'(count),   32'd0);
        chk("t2_empty", 32'(empty),   32'd1);

        // Level-high valid gives exactly one capture.
        op = 2'b01; s = 4'd12; cout = 1'b1; valid = 1'b1;
        cyc(10);
        valid = 1'b0;
        cyc(1);
        chk("t3_count", 32'(count), 32'd1);
        rd_pulse();
        chk("t3_cs", 32'({q_cout, q_s}), 32'b11100);
        chk("t3_op", 32'(q_op), 32'd1);

        // Fill past full; ninth capture is dropped.
        for (int i = 0; i < 9; i++) begin
            push(2'(i), 4'(i), 1'b0);
            if (i == 7) begin
                chk("t4_full8", 32'(full), 32'd1);
                chk("t4_ovf8",  32'(ovf),  32'd0);
            end
        end
        chk("t4_ovf9",  32'(ovf),   32'd1);
        chk("t4_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            rd_pulse();
            chk("t4_drain_qv", 32'(q_valid), 32'd1);
            chk("t4_drain_s",  32'(q_s),     32'(i));
        end
        rd_pulse();
        chk("t4_empty_rd_qv", 32'(q_valid), 32'd0);
        chk("t4_empty_rd_s",  32'(q_s),     32'd7);
        chk("t4_ovf_sticky",  32'(ovf),     32'd1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("t4_clr_ovf", 32'(ovf), 32'd0);

        // Full FIFO: capture and read together.
        for (int i = 0; i < 8; i++) push(2'b10, 4'(i), 1'b0);
        chk("t5_full", 32'(full), 32'd1);
        op = 2'b11; s = 4'd15; cout = 1'b1; valid = 1'b1; rd = 1'b1;
        cyc(1);
        valid = 1'b0; rd = 1'b0;
        chk("t5_count", 32'(count),   32'd8);
        chk("t5_ovf",   32'(ovf),     32'd0);
        chk("t5_qv",    32'(q_valid), 32'd1);
        chk("t5_s0",    32'(q_s),     32'd0);
        cyc(1);
        for (int i = 1; i < 8; i++) begin
            rd_pulse();
            chk("t5_old_s", 32'(q_s), 32'(i));
        end
        rd_pulse();
        chk("t5_new_s",    32'(q_s),    32'd15);
        chk("t5_new_cout", 32'(q_cout), 32'd1);
        chk("t5_new_op",   32'(q_op),   32'd3);
        chk("t5_empty",    32'(empty),  32'd1);

        // Flush with a simultaneous capture.
        for (int i = 0; i < 3; i++) push(2'b00, 4'(i + 4), 1'b1);
        chk("t6_count3", 32'(count), 32'd3);
        op = 2'b01; s = 4'd3; cout = 1'b0; valid = 1'b1; clr = 1'b1;
        cyc(1);
        valid = 1'b0; clr = 1'b0;
        chk("t6_count", 32'(count),   32'd0);
        chk("t6_empty", 32'(empty),   32'd1);
        chk("t6_ovf",   32'(ovf),     32'd0);
        chk("t6_qv",    32'(q_valid), 32'd0);
        cyc(1);
        rd_pulse();
        chk("t6_rd_qv",   32'(q_valid), 32'd0);
        chk("t6_hold_s",  32'(q_s),     32'd15);

        // Asynchronous reset mid-operation.
        push(2'b10, 4'd6, 1'b0);
        push(2'b10, 4'd7, 1'b0);
        rd_pulse();
        #3 rst = 1'b1;
        #1;
        chk("t7_count", 32'(count),   32'd0);
        chk("t7_empty", 32'(empty),   32'd1);
        chk("t7_q_s",   32'(q_s),     32'd0);
        chk("t7_qv",    32'(q_valid), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
